line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte offset added to every backing-port address.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port s_addr  input  32  line byte address; bits [3:0] ignored.
REQ-005 SHALL have port s_writedata  input  128  write line; word 0 in bits [31:0].
REQ-006 SHALL have port s_read  input  1  line read request.
REQ-007 SHALL have port s_write  input  1  line write request.
REQ-008 SHALL have port s_readdata  output  128  assembled read line.
REQ-009 SHALL have port s_readdata_valid  output  1  one-cycle read-line strobe.
REQ-010 SHALL have port s_waitrequest  output  1  high while busy; request accepted when s_read or s_write is high and s_waitrequest is low.
REQ-011 SHALL have port w_addr  output  32  backing word byte address.
REQ-012 SHALL have ports w_writedata  output  32  write word; w_read  output  1  and w_write  output  1  beat strobes.
REQ-013 SHALL have ports w_readdata  input  32  read word; w_readdata_valid  input  1  in-order word return; w_waitrequest  input  1  backing stall.

Function
REQ-014 SHALL implement FSM IDLE, WR_BEAT, RD_ISSUE, RD_DONE.
REQ-015 SHALL drive s_waitrequest low only in IDLE, combinationally from state.
REQ-016 SHALL, in IDLE on an accepted request, latch s_addr[31:4] and s_writedata, clear beat counters, and go to WR_BEAT (write) or RD_ISSUE (read).
REQ-017 SHALL give priority to write when s_read and s_write are both high in IDLE; the read is dropped.
REQ-018 SHALL drive w_addr = ADDR_BASE + {line[31:4], beat[1:0], 2'b00}, modulo 2^32.
REQ-019 SHALL, in WR_BEAT, hold w_write high with w_writedata = line word[beat]; beat advances only when w_waitrequest is low; return to IDLE the cycle after beat 3 is accepted. No write response.
REQ-020 SHALL, in RD_ISSUE, hold w_read high while issue count < 4; advance on !w_waitrequest; drop w_read after 4 issues.
REQ-021 SHALL store each w_readdata_valid word into slot rcv_cnt (0..3), including words arriving during issue and the same cycle as an issue.
REQ-022 SHALL enter RD_DONE after the 4th word is received; in RD_DONE assert s_readdata_valid for exactly one cycle with the full line, then go to IDLE.
REQ-023 SHALL hold s_readdata stable from RD_DONE until the next read completes.
REQ-024 SHALL ignore w_readdata_valid in IDLE and WR_BEAT.
REQ-025 SHALL give minimum read latency, acceptance to s_readdata_valid, of 6 cycles with zero-wait, 1-cycle backing latency.
REQ-026 SHALL keep w_read and w_write never high together, and both low in IDLE and RD_DONE.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, go to IDLE, zero counters, s_readdata, s_readdata_valid, w_read, w_write, w_addr and w_writedata, aborting any operation mid-beat.
REQ-028 SHALL not track backing responses still in flight across reset; the backing memory SHALL be reset together with this block.

Configuration
REQ-029 SHALL, with LINE_RESP_STATS_EN defined, add outputs cnt_rd_lines and cnt_wr_lines (32 bits each), counting completed lines, wrapping at 2^32, reset to 0.
REQ-030 SHALL, without LINE_RESP_STATS_EN, omit those ports and counters, with otherwise identical behaviour.

Structure
REQ-031 SHALL take LINE_W=128, WORD_W=32, BEATS=4 and the state enum from shared package line_bus_pkg.
REQ-032 SHALL be a single module with no sub-module.

Verification
REQ-033 SHALL cover: write addr 0x100, line 0x4444_4444_3333_3333_2222_2222_1111_1111, zero wait -> w_addr 0x100/104/108/10C with data 1111_1111..4444_4444 on consecutive cycles.
REQ-034 SHALL cover: read addr 0x20F, backing returns A0,A1,A2,A3 with 1-cycle latency -> one s_readdata_valid with line {A3,A2,A1,A0}, w_addr starting at 0x200.
REQ-035 SHALL cover: w_waitrequest high 3 cycles on beat 2 of a write -> beat 2 held, no beat skipped or duplicated.
REQ-036 SHALL cover: s_read=s_write=1 at addr 0x40 -> 4 writes only, no s_readdata_valid.
REQ-037 SHALL cover: rst_n low after 2 read words received -> next cycle all outputs 0, s_waitrequest low, subsequent read correct.
REQ-038 SHALL cover: ADDR_BASE=0x1000_0000, read addr 0xFFFF_FFF0 -> w_addr wraps to 0x0FFF_FFF0..0x0FFF_FFFC.

Source files
------------

// File: rtl/line_bus_pkg.sv
// Shared line-bus definitions: line/word geometry and the responder FSM states.
package line_bus_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BEAT,
    ST_RD_ISSUE,
    ST_RD_DONE
  } state_e;

  // Word idx of a line; word 0 sits in the least significant bits.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        idx);
    return line[WORD_W*int'(idx) +: WORD_W];
  endfunction

endpackage

// File: rtl/line_mem_responder.sv
// Line-to-word memory responder: turns 128-bit line reads/writes into four 32-bit backing beats.
// Defining LINE_RESP_STATS_EN adds the cnt_rd_lines/cnt_wr_lines completed-line counters.
module line_mem_responder
  import line_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_addr,
  input  logic [LINE_W-1:0] s_writedata,
  input  logic              s_read,
  input  logic              s_write,
  output logic [LINE_W-1:0] s_readdata,
  output logic              s_readdata_valid,
  output logic              s_waitrequest,
  output logic [31:0]       w_addr,
  output logic [WORD_W-1:0] w_writedata,
  output logic              w_read,
  output logic              w_write,
  input  logic [WORD_W-1:0] w_readdata,
  input  logic              w_readdata_valid,
  input  logic              w_waitrequest
`ifdef LINE_RESP_STATS_EN
  ,
  output logic [31:0]       cnt_rd_lines,
  output logic [31:0]       cnt_wr_lines
`endif
);

  state_e              state_q, state_d;
  logic [27:0]         line_q, line_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          beat_q, beat_d;
  logic [1:0]          rcv_q, rcv_d;
  logic [WORD_W-1:0]   rbuf_q [BEATS-1];
  logic [WORD_W-1:0]   rbuf_d [BEATS-1];
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                wr_last;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^s_addr[3:0];

  assign s_waitrequest    = (state_q != ST_IDLE);
  assign s_readdata_valid = (state_q == ST_RD_DONE);
  assign s_readdata       = rdata_q;

  // beat_q doubles as the write beat index and the read issue count (0..4).
  assign w_write     = (state_q == ST_WR_BEAT);
  assign w_read      = (state_q == ST_RD_ISSUE) && !beat_q[2];
  assign w_addr      = (w_read || w_write) ? ADDR_BASE + {line_q, beat_q[1:0], 2'b00} : '0;
  assign w_writedata = w_write ? line_word(wdata_q, beat_q[1:0]) : '0;
  assign wr_last     = w_write && !w_waitrequest && (beat_q[1:0] == 2'd3);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    rcv_d   = rcv_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_write || s_read) begin
          line_d  = s_addr[31:4];
          wdata_d = s_writedata;
          beat_d  = '0;
          rcv_d   = '0;
          state_d = s_write ? ST_WR_BEAT : ST_RD_ISSUE;
        end
      end
      ST_WR_BEAT: begin
        if (!w_waitrequest) begin
          beat_d = beat_q + 3'd1;
          if (wr_last) state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        if (w_read && !w_waitrequest) beat_d = beat_q + 3'd1;
        // Returned words are collected even while issues are still going out.
        if (w_readdata_valid) begin
          rcv_d = rcv_q + 2'd1;
          unique case (rcv_q)
            2'd0: rbuf_d[0] = w_readdata;
            2'd1: rbuf_d[1] = w_readdata;
            2'd2: rbuf_d[2] = w_readdata;
            default: begin
              rdata_d = {w_readdata, rbuf_q[2], rbuf_q[1], rbuf_q[0]};
              state_d = ST_RD_DONE;
            end
          endcase
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      rcv_q   <= '0;
      rbuf_q  <= '{default: '0};
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      rcv_q   <= rcv_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LINE_RESP_STATS_EN
  logic [31:0] cnt_rd_q, cnt_wr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_rd_q <= '0;
      cnt_wr_q <= '0;
    end else begin
      if (state_q == ST_RD_DONE) cnt_rd_q <= cnt_rd_q + 32'd1;
      if (wr_last)               cnt_wr_q <= cnt_wr_q + 32'd1;
    end
  end

  assign cnt_rd_lines = cnt_rd_q;
  assign cnt_wr_lines = cnt_wr_q;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a behavioural backing memory plus a line-level reference model.
// A second instance with ADDR_BASE=0x1000_0000 shares all inputs to check address offset and wrap.
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_addr = '0;
  logic [127:0] s_writedata = '0;
  logic         s_read = 1'b0;
  logic         s_write = 1'b0;
  logic [127:0] s_readdata, hReaddata;
  logic         s_readdata_valid, hReaddataValid;
  logic         s_waitrequest, hWaitrequest;
  logic [31:0]  w_addr, hAddr;
  logic [31:0]  w_writedata, hWritedata;
  logic         w_read, w_write, hRead, hWrite;
  logic [31:0]  w_readdata = '0;
  logic         w_readdata_valid = 1'b0;
  logic         w_waitrequest = 1'b0;
`ifdef LINE_RESP_STATS_EN
  logic [31:0]  cntRd, cntWr, hCntRd, hCntWr;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .s_addr(s_addr), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata),
    .s_readdata_valid(s_readdata_valid), .s_waitrequest(s_waitrequest),
    .w_addr(w_addr), .w_writedata(w_writedata), .w_read(w_read), .w_write(w_write),
    .w_readdata(w_readdata), .w_readdata_valid(w_readdata_valid),
    .w_waitrequest(w_waitrequest)
`ifdef LINE_RESP_STATS_EN
    , .cnt_rd_lines(cntRd), .cnt_wr_lines(cntWr)
`endif
  );

  line_mem_responder #(.ADDR_BASE(32'h1000_0000)) dutHi (
    .clk(clk), .rst_n(rst_n), .s_addr(s_addr), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_readdata(hReaddata),
    .s_readdata_valid(hReaddataValid), .s_waitrequest(hWaitrequest),
    .w_addr(hAddr), .w_writedata(hWritedata), .w_read(hRead), .w_write(hWrite),
    .w_readdata(w_readdata), .w_readdata_valid(w_readdata_valid),
    .w_waitrequest(w_waitrequest)
`ifdef LINE_RESP_STATS_EN
    , .cnt_rd_lines(hCntRd), .cnt_wr_lines(hCntWr)
`endif
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } beat_t;
  typedef struct { logic [127:0] data; logic [127:0] hData; logic hValid; int cyc; } line_t;
  typedef struct { logic [31:0] data; int due; } resp_t;

  // Backing memory contents and what it observed on the word port.
  logic [31:0] bkMem  [logic [31:0]];
  logic [31:0] expMem [logic [31:0]];
  beat_t       wrLog [$];
  logic [31:0] rdLog [$];
  logic [31:0] hiLog [$];
  line_t       rvLog [$];
  resp_t       pend [$];
  int cyc = 0, accCyc = 0, rcvCount = 0, bothHigh = 0, idleActive = 0, stallLeft = 0;
  int rdLat = 1, wsMode = 0, expRd = 0, expWr = 0;

  function automatic logic [31:0] fill_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return expMem.exists(a) ? expMem[a] : fill_word(a);
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] addr);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = exp_word({addr[31:4], 4'b0} + 32'(4*i));
    return l;
  endfunction

  // Backing memory: fixed read latency rdLat, programmable stalls, in-order returns.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend.delete();
      stallLeft = 0;
      w_waitrequest    <= 1'b0;
      w_readdata_valid <= 1'b0;
      w_readdata       <= '0;
    end else begin
      if (!s_waitrequest && (s_read || s_write)) accCyc = cyc;
      if (w_read && w_write) bothHigh++;
      if ((!s_waitrequest || s_readdata_valid) && (w_read || w_write)) idleActive++;
      if (s_readdata_valid) rvLog.push_back('{s_readdata, hReaddata, hReaddataValid, cyc});
      if (w_readdata_valid) rcvCount++;
      if (w_write && !w_waitrequest) begin
        if (wsMode == 2 && (wrLog.size() % 4) == 1) stallLeft = 3;
        wrLog.push_back('{w_addr, w_writedata, cyc});
        bkMem[w_addr] = w_writedata;
      end
      if (w_read && !w_waitrequest) begin
        rdLog.push_back(w_addr);
        hiLog.push_back(hAddr);
        pend.push_back('{bkMem.exists(w_addr) ? bkMem[w_addr] : fill_word(w_addr), cyc + rdLat - 1});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        w_readdata       <= pend[0].data;
        w_readdata_valid <= 1'b1;
        void'(pend.pop_front());
      end else begin
        w_readdata       <= $urandom();
        w_readdata_valid <= 1'b0;
      end
      if (stallLeft > 0) begin
        w_waitrequest <= 1'b1;
        stallLeft--;
      end else if (wsMode == 1) w_waitrequest <= ($urandom_range(0, 2) == 0);
      else w_waitrequest <= 1'b0;
    end
  end

  // Presents one request and updates the line model from the stimulus.
  task automatic send_req(input logic [31:0] addr, input logic [127:0] data,
                          input logic rd, input logic wr);
    int guard = 0;
    @(negedge clk);
    while (s_waitrequest && guard < 300) begin @(negedge clk); guard++; end
    checkCount++;
    if (s_waitrequest !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL accept_timeout: s_waitrequest=%0b expected 0", s_waitrequest);
    end
    s_addr = addr; s_writedata = data; s_read = rd; s_write = wr;
    if (wr) begin
      for (int i = 0; i < 4; i++) expMem[{addr[31:4], 4'b0} + 32'(4*i)] = data[32*i +: 32];
      expWr++;
    end else if (rd) expRd++;
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0; s_addr = $urandom(); s_writedata = {4{$urandom()}};
  endtask

  task automatic wait_done();
    int guard = 0;
    @(negedge clk);
    while ((s_waitrequest || pend.size() != 0) && guard < 300) begin @(negedge clk); guard++; end
    checkCount++;
    if (s_waitrequest !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL done_timeout: s_waitrequest=%0b expected 0", s_waitrequest);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if ({s_waitrequest, s_readdata_valid, w_read, w_write} !== 4'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {s_waitrequest, s_readdata_valid, w_read, w_write});
    end
    checkCount++;
    if (w_addr !== 32'h0 || hAddr !== 32'h0 || w_writedata !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_word_port: addr=%h hiAddr=%h wdata=%h expected 0", w_addr, hAddr, w_writedata);
    end
    checkCount++;
    if (s_readdata !== 128'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_readdata: got %h expected 0", s_readdata);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    int n0;
    logic [31:0] expA [4];
    logic [31:0] expD [4];
    expA = '{32'h100, 32'h104, 32'h108, 32'h10C};
    expD = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    wsMode = 0; rdLat = 1;
    n0 = wrLog.size();
    send_req(32'h100, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 1'b0, 1'b1);
    wait_done();
    checkCount++;
    if (wrLog.size() != n0 + 4) begin
      errorCount++;
      $display("[TB] FAIL write_basic_beats: got %0d expected 4", wrLog.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checkCount++;
        if (wrLog[n0+i].addr !== expA[i] || wrLog[n0+i].data !== expD[i] ||
            (i > 0 && wrLog[n0+i].cyc != wrLog[n0+i-1].cyc + 1)) begin
          errorCount++;
          $display("[TB] FAIL write_basic_beat%0d: addr=%h data=%h expected addr=%h data=%h consecutive",
                   i, wrLog[n0+i].addr, wrLog[n0+i].data, expA[i], expD[i]);
        end
      end
    end
  endtask

  task automatic test_read_basic();
    int rv0, is0;
    for (int i = 0; i < 4; i++) begin
      bkMem[32'h200 + 32'(4*i)]  = 32'hAAAA_0000 + 32'(i);
      expMem[32'h200 + 32'(4*i)] = 32'hAAAA_0000 + 32'(i);
    end
    wsMode = 0; rdLat = 1;
    rv0 = rvLog.size(); is0 = rdLog.size();
    send_req(32'h20F, {4{$urandom()}}, 1'b1, 1'b0);
    wait_done();
    checkCount++;
    if (rvLog.size() != rv0 + 1) begin
      errorCount++;
      $display("[TB] FAIL read_basic_strobes: got %0d expected 1", rvLog.size() - rv0);
    end else begin
      checkCount++;
      if (rvLog[rv0].data !== 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000) begin
        errorCount++;
        $display("[TB] FAIL read_basic_line: got %h expected AAAA0003AAAA0002AAAA0001AAAA0000", rvLog[rv0].data);
      end
      checkCount++;
      if (rvLog[rv0].cyc - accCyc != 6) begin
        errorCount++;
        $display("[TB] FAIL read_latency: got %0d expected 6", rvLog[rv0].cyc - accCyc);
      end
    end
    checkCount++;
    if (rdLog.size() != is0 + 4 || rdLog[is0] !== 32'h200) begin
      errorCount++;
      $display("[TB] FAIL read_basic_issue: issues=%0d first=%h expected 4 from 00000200", rdLog.size() - is0, rdLog[is0]);
    end
  endtask

  task automatic test_write_stall();
    int n0;
    int expOff [4];
    logic [127:0] data;
    expOff = '{0, 1, 5, 6};
    data = {$urandom(), $urandom(), $urandom(), $urandom()};
    wsMode = 2;
    n0 = wrLog.size();
    send_req(32'h500 | 32'($urandom_range(0, 15)), data, 1'b0, 1'b1);
    wait_done();
    wsMode = 0;
    checkCount++;
    if (wrLog.size() != n0 + 4) begin
      errorCount++;
      $display("[TB] FAIL write_stall_beats: got %0d expected 4", wrLog.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checkCount++;
        if (wrLog[n0+i].addr !== 32'h500 + 32'(4*i) || wrLog[n0+i].data !== data[32*i +: 32] ||
            wrLog[n0+i].cyc - wrLog[n0].cyc != expOff[i]) begin
          errorCount++;
          $display("[TB] FAIL write_stall_beat%0d: addr=%h data=%h off=%0d expected addr=%h data=%h off=%0d",
                   i, wrLog[n0+i].addr, wrLog[n0+i].data, wrLog[n0+i].cyc - wrLog[n0].cyc,
                   32'h500 + 32'(4*i), data[32*i +: 32], expOff[i]);
        end
      end
    end
  endtask

  task automatic test_both();
    int n0, rv0, is0;
    logic [127:0] data;
    data = {$urandom(), $urandom(), $urandom(), $urandom()};
    n0 = wrLog.size(); rv0 = rvLog.size(); is0 = rdLog.size();
    send_req(32'h40, data, 1'b1, 1'b1);
    wait_done();
    repeat (8) @(negedge clk);
    checkCount++;
    if (wrLog.size() != n0 + 4 || rdLog.size() != is0 || rvLog.size() != rv0) begin
      errorCount++;
      $display("[TB] FAIL both_priority: writes=%0d reads=%0d strobes=%0d expected 4/0/0",
               wrLog.size() - n0, rdLog.size() - is0, rvLog.size() - rv0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checkCount++;
        if (wrLog[n0+i].addr !== 32'h40 + 32'(4*i) || wrLog[n0+i].data !== data[32*i +: 32]) begin
          errorCount++;
          $display("[TB] FAIL both_beat%0d: addr=%h data=%h expected addr=%h data=%h",
                   i, wrLog[n0+i].addr, wrLog[n0+i].data, 32'h40 + 32'(4*i), data[32*i +: 32]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc0, rv0, guard;
    logic [127:0] expL;
    wsMode = 0; rdLat = 1;
    rc0 = rcvCount; rv0 = rvLog.size(); guard = 0;
    send_req(32'h300, {4{$urandom()}}, 1'b1, 1'b0);
    while (rcvCount < rc0 + 2 && guard < 50) begin @(negedge clk); guard++; end
    checkCount++;
    if (rcvCount < rc0 + 2) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_words: got %0d expected 2", rcvCount - rc0);
    end
    rst_n = 1'b0;
    expRd = 0; expWr = 0;
    @(posedge clk); #1;
    checkCount++;
    if ({s_waitrequest, s_readdata_valid, w_read, w_write} !== 4'b0 || w_addr !== 32'h0 ||
        w_writedata !== 32'h0 || s_readdata !== 128'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_outputs: wait/valid/rd/wr=%b addr=%h wdata=%h rdata=%h expected all 0",
               {s_waitrequest, s_readdata_valid, w_read, w_write}, w_addr, w_writedata, s_readdata);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkCount++;
    if (rvLog.size() != rv0) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_abort: strobes=%0d expected 0", rvLog.size() - rv0);
    end
    expL = exp_line(32'h300);
    send_req(32'h304, {4{$urandom()}}, 1'b1, 1'b0);
    wait_done();
    checkCount++;
    if (rvLog.size() != rv0 + 1 || rvLog[rv0].data !== expL) begin
      errorCount++;
      $display("[TB] FAIL reset_mid_reread: strobes=%0d line=%h expected 1 line=%h",
               rvLog.size() - rv0, rvLog[rv0].data, expL);
    end
  endtask

  task automatic test_addr_wrap();
    int rv0, is0;
    logic [127:0] expL;
    logic [31:0] hiExp [4];
    hiExp = '{32'h0FFF_FFF0, 32'h0FFF_FFF4, 32'h0FFF_FFF8, 32'h0FFF_FFFC};
    wsMode = 0; rdLat = 2;
    rv0 = rvLog.size(); is0 = hiLog.size();
    expL = exp_line(32'hFFFF_FFF0);
    send_req(32'hFFFF_FFF0, {4{$urandom()}}, 1'b1, 1'b0);
    wait_done();
    checkCount++;
    if (hiLog.size() != is0 + 4) begin
      errorCount++;
      $display("[TB] FAIL wrap_issues: got %0d expected 4", hiLog.size() - is0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checkCount++;
        if (hiLog[is0+i] !== hiExp[i] || rdLog[is0+i] !== 32'hFFFF_FFF0 + 32'(4*i)) begin
          errorCount++;
          $display("[TB] FAIL wrap_addr%0d: hi=%h base0=%h expected hi=%h base0=%h",
                   i, hiLog[is0+i], rdLog[is0+i], hiExp[i], 32'hFFFF_FFF0 + 32'(4*i));
        end
      end
    end
    checkCount++;
    if (rvLog.size() != rv0 + 1 || rvLog[rv0].hValid !== 1'b1 || rvLog[rv0].hData !== expL) begin
      errorCount++;
      $display("[TB] FAIL wrap_line: strobes=%0d hiValid=%b line=%h expected 1/1 line=%h",
               rvLog.size() - rv0, rvLog[rv0].hValid, rvLog[rv0].hData, expL);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int op, n0, rv0;
      logic [31:0] addr;
      logic [127:0] data, expL;
      wsMode = 1;
      rdLat = $urandom_range(1, 3);
      op = $urandom_range(0, 2);
      addr = 32'h800 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15);
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      n0 = wrLog.size(); rv0 = rvLog.size();
      if (op == 1) begin
        expL = exp_line(addr);
        send_req(addr, data, 1'b1, 1'b0);
        wait_done();
        checkCount++;
        if (rvLog.size() != rv0 + 1 || rvLog[rv0].data !== expL) begin
          errorCount++;
          $display("[TB] FAIL random_read%0d: strobes=%0d line=%h expected 1 line=%h",
                   k, rvLog.size() - rv0, rvLog[rv0].data, expL);
        end
      end else begin
        send_req(addr, data, (op == 2), 1'b1);
        wait_done();
        checkCount++;
        if (wrLog.size() != n0 + 4) begin
          errorCount++;
          $display("[TB] FAIL random_write%0d_beats: got %0d expected 4", k, wrLog.size() - n0);
        end else begin
          for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (wrLog[n0+i].addr !== {addr[31:4], 4'b0} + 32'(4*i) || wrLog[n0+i].data !== data[32*i +: 32]) begin
              errorCount++;
              $display("[TB] FAIL random_write%0d_beat%0d: addr=%h data=%h expected addr=%h data=%h",
                       k, i, wrLog[n0+i].addr, wrLog[n0+i].data, {addr[31:4], 4'b0} + 32'(4*i), data[32*i +: 32]);
            end
          end
        end
      end
    end
    wsMode = 0;
  endtask

  task automatic test_invariants();
    checkCount++;
    if (bothHigh != 0 || idleActive != 0) begin
      errorCount++;
      $display("[TB] FAIL strobe_rules: bothHigh=%0d activeWhenIdleOrDone=%0d expected 0/0", bothHigh, idleActive);
    end
  endtask

`ifdef LINE_RESP_STATS_EN
  task automatic test_stats();
    checkCount++;
    if (cntRd !== 32'(expRd) || cntWr !== 32'(expWr)) begin
      errorCount++;
      $display("[TB] FAIL stats: rd=%0d wr=%0d expected rd=%0d wr=%0d", cntRd, cntWr, expRd, expWr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_stall();
    test_both();
    test_reset_mid();
    test_addr_wrap();
    test_random();
    test_invariants();
`ifdef LINE_RESP_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
